// File: rtl/dbg_pkg.sv
// Shared definitions for the debug register readout block.
package dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND
    } state_t;

    localparam int BYTE_W      = 8;
    localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/dbg_shift_reg.sv
// Capture register for the readout data; parallel load, shift right one byte at a time.
module dbg_shift_reg
    import dbg_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [size-1:0] load_data,
    input  logic            shift,
    output logic [size-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= data >> BYTE_W;
        end
    end

endmodule

// File: rtl/dbg_reg_readout.sv
// Host-driven register read: fetch one register-file word, stream it out LSB byte first.
module dbg_reg_readout
    import dbg_pkg::*;
#(
    parameter int size    = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    input  logic [AW-1:0]   cmd_addr,
    output logic            cmd_ready,
    output logic            rf_req,
    output logic [AW-1:0]   rf_addr,
    input  logic            rf_ack,
    input  logic [size-1:0] rf_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [7:0]      tx_byte,
    output logic            busy,
    output logic            timeout_err
);

    localparam int NB = size / BYTE_W;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(NB + 1);

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [BW-1:0]   byte_cnt;
    logic            timeout_hit;
    logic            last_byte;
    logic            sr_load;
    logic            sr_shift;
    logic [size-1:0] sr_load_data;
    logic [size-1:0] sr_data;

    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
    assign last_byte   = (byte_cnt == BW'(NB - 1));
    assign tx_byte     = sr_data[BYTE_W-1:0];

    // An ack on the timeout cycle wins over the all-ones fill.
    always_comb begin
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_load_data = rf_data;
        if (state == ST_REQ) begin
            if (rf_ack) begin
                sr_load = 1'b1;
            end else if (timeout_hit) begin
                sr_load      = 1'b1;
                sr_load_data = '1;
            end
        end
        if (state == ST_SEND && tx_valid && tx_ready) begin
            sr_shift = 1'b1;
        end
    end

    dbg_shift_reg #(
        .size(size)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (sr_load),
        .load_data (sr_load_data),
        .shift     (sr_shift),
        .data      (sr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            byte_cnt    <= '0;
            rf_addr     <= '0;
            cmd_ready   <= 1'b1;
            rf_req      <= 1'b0;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        rf_addr     <= cmd_addr;
                        timeout_err <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= ST_REQ;
                        cmd_ready   <= 1'b0;
                        rf_req      <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (rf_ack || timeout_hit) begin
                        byte_cnt <= '0;
                        state    <= ST_SEND;
                        rf_req   <= 1'b0;
                        tx_valid <= 1'b1;
                        if (!rf_ack) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        byte_cnt <= byte_cnt + BW'(1);
                        if (last_byte) begin
                            state     <= ST_IDLE;
                            tx_valid  <= 1'b0;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rf_req    <= 1'b0;
                    tx_valid  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dbg_reg_readout.md
DBG_REG_READOUT -- requirements
Module: dbg_reg_readout

Interface
REQ-001 Parameter size, default 32, SHALL be the captured data width in bits and a multiple of 8.
REQ-002 Parameter AW, default 5, SHALL be the register-address width.
REQ-003 Parameter TIMEOUT, default 15, SHALL be the max cycles spent waiting for rf_ack.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset, sampled on rising clk.
REQ-006 cmd_valid  input  1  SHALL indicate a host read command is present.
REQ-007 cmd_addr  input  AW  SHALL give the register index to read.
REQ-008 cmd_ready  output  1  SHALL indicate the block can accept a command.
REQ-009 rf_req  output  1  SHALL request a register-file read.
REQ-010 rf_addr  output  AW  SHALL carry the latched register index.
REQ-011 rf_ack  input  1  SHALL qualify rf_data as valid this cycle.
REQ-012 rf_data  input  size  SHALL carry the register value.
REQ-013 tx_valid  output  1  SHALL indicate tx_byte holds a byte for the host.
REQ-014 tx_ready  input  1  SHALL indicate the host accepts tx_byte this cycle.
REQ-015 tx_byte  output  8  SHALL carry the outgoing byte.
REQ-016 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-017 timeout_err  output  1  SHALL be a sticky flag set when a read timed out.

Function
REQ-018 FSM SHALL have states IDLE, REQ and SEND; no other states.
REQ-019 IDLE: cmd_ready=1. When cmd_valid=1, the block SHALL latch cmd_addr, clear timeout_err, clear the wait counter and go to REQ next cycle.
REQ-020 REQ: rf_req=1, rf_addr=latched index. When rf_ack=1, the block SHALL capture rf_data into the shift register, clear the byte counter and go to SEND.
REQ-021 REQ timeout: the wait counter SHALL increment each cycle without rf_ack. On the cycle the counter equals TIMEOUT-1 with no ack, the block SHALL load all-ones, set timeout_err and go to SEND.
REQ-022 rf_ack arriving on the timeout cycle SHALL take priority: data captured, timeout_err not set.
REQ-023 SEND: tx_valid=1, tx_byte=shift register bits [7:0], LSB byte first.
REQ-024 On tx_valid&&tx_ready, the block SHALL shift the register right by 8 and increment the byte counter. After byte size/8 is accepted, it SHALL return to IDLE.
REQ-025 While tx_valid=1 and tx_ready=0, tx_byte SHALL hold stable. tx_valid SHALL not drop until a byte is accepted.
REQ-026 cmd_ready SHALL be 0 outside IDLE; cmd_valid in REQ or SEND SHALL be ignored, not queued.
REQ-027 rf_ack outside REQ SHALL be ignored.
REQ-028 Latency: command accept -> rf_req = 1 cycle; rf_ack -> first tx_valid = 1 cycle; back-to-back bytes every cycle when tx_ready is held at 1.
REQ-029 The block SHALL accept a new command in the IDLE cycle immediately following the last byte.

Reset
REQ-030 rst SHALL force IDLE from any state, including mid-REQ and mid-SEND, and abort any transfer in progress without emitting further bytes.
REQ-031 Reset values SHALL be: cmd_ready=1 (IDLE), rf_req=0, rf_addr=0, tx_valid=0, tx_byte=0, busy=0, timeout_err=0. Counters and the shift register SHALL reset to 0.

Structure
REQ-032 Package dbg_pkg SHALL hold the state enumeration, BYTE_W=8 and the default TIMEOUT constant.
REQ-033 A single sub-module, dbg_shift_reg (size-bit, parallel load, shift-right-by-8 enable), SHALL hold the captured data. The FSM and counters SHALL stay in dbg_reg_readout.

Verification
REQ-034 Basic read: cmd_addr=5'd3; rf_ack after 2 cycles with rf_data=32'h12345678; tx_ready=1 -> bytes 78,56,34,12; busy low on the next cycle; timeout_err=0.
REQ-035 Backpressure: tx_ready toggled 0,0,1 repeatedly -> each byte held stable while stalled; order 78,56,34,12; exactly 4 handshakes.
REQ-036 Timeout: rf_ack never asserted -> after 15 REQ cycles, timeout_err=1; bytes FF,FF,FF,FF. The next command clears timeout_err.
REQ-037 Ack on last cycle: rf_ack on REQ cycle 15 with rf_data=32'hA5A5_0001 -> bytes 01,00,A5,A5; timeout_err=0.
REQ-038 Reset mid-SEND: rst asserted after the second byte -> next cycle tx_valid=0, cmd_ready=1, all outputs at reset values; a new command completes normally.
REQ-039 Ignored input: cmd_valid held high during SEND and rf_ack pulsed during IDLE -> no extra rf_req and no extra bytes.
